// File: rtl/vlc_packer_if.sv
// Codeword input and packed-word output bundle for vlc_packer.
// The packer sits on the slave side; the symbol source and word sink sit on the master side.
interface vlc_packer_if #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = 5
);
  logic               iValid;
  logic [MAX_LEN-1:0] iCode;
  logic [LEN_W-1:0]   iLen;
  logic               oReady;
  logic [WORD_W-1:0]  oWord;
  logic               oWordValid;
  logic               oDone;

  modport master (
    output iValid, iCode, iLen,
    input  oReady, oWord, oWordValid, oDone
  );

  modport slave (
    input  iValid, iCode, iLen,
    output oReady, oWord, oWordValid, oDone
  );
endinterface

// File: rtl/vlc_packer.sv
// Packs MSB-first variable-length codewords into WORD_W-bit words, one block of
// BLOCK_SYMS symbols at a time, then flushes the tail and holds oDone until iSoftRst.
module vlc_packer #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned LEN_W      = 5,
  parameter int unsigned BLOCK_SYMS = 64,
  parameter int unsigned CNT_W      = 7
) (
  input  logic         iClk,
  input  logic         iRst_n,
  input  logic         iSoftRst,
  vlc_packer_if.slave  bus
);

  localparam int unsigned ACC_W  = WORD_W + MAX_LEN - 1;
  localparam int unsigned FILL_W = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} packState_t;

  packState_t        state;
  logic [ACC_W-1:0]  acc;
  logic [FILL_W-1:0] fill;
  logic [CNT_W-1:0]  symCnt;
  logic [WORD_W-1:0] wordQ;
  logic              wordValidQ;
  logic              doneQ;

  logic              readyC;
  logic              acceptC;
  logic [LEN_W-1:0]  lenClampC;
  logic [ACC_W-1:0]  codeBitsC;
  logic [FILL_W-1:0] fillSumC;
  logic [FILL_W-1:0] shAmtC;
  logic [ACC_W-1:0]  accSumC;

  assign readyC         = (state == RUN) && !iSoftRst;
  assign acceptC        = bus.iValid && readyC;
  assign bus.oReady     = readyC;
  assign bus.oWord      = wordQ;
  assign bus.oWordValid = wordValidQ;
  assign bus.oDone      = doneQ;

  // Accumulator is MSB-aligned: new bits land directly below the current fill.
  // fill stays below WORD_W between symbols, so fill+len never exceeds ACC_W.
  always_comb begin
    lenClampC = (bus.iLen > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.iLen;
    codeBitsC = ACC_W'(bus.iCode) & ~({ACC_W{1'b1}} << lenClampC);
    fillSumC  = fill + FILL_W'(lenClampC);
    shAmtC    = FILL_W'(ACC_W) - fillSumC;
    accSumC   = acc | (codeBitsC << shAmtC);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state      <= RUN;
      acc        <= '0;
      fill       <= '0;
      symCnt     <= '0;
      wordQ      <= '0;
      wordValidQ <= 1'b0;
      doneQ      <= 1'b0;
    end else begin
      wordValidQ <= 1'b0;
      if (iSoftRst) begin
        // Restart drops any buffered bits without flushing them.
        state  <= RUN;
        acc    <= '0;
        fill   <= '0;
        symCnt <= '0;
        doneQ  <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            if (acceptC) begin
              symCnt <= symCnt + 1'b1;
              if (fillSumC >= FILL_W'(WORD_W)) begin
                wordQ      <= accSumC[ACC_W-1 -: WORD_W];
                wordValidQ <= 1'b1;
                acc        <= accSumC << WORD_W;
                fill       <= fillSumC - FILL_W'(WORD_W);
              end else begin
                acc  <= accSumC;
                fill <= fillSumC;
              end
              if (symCnt == CNT_W'(BLOCK_SYMS - 1)) state <= FLUSH;
            end
          end
          FLUSH: begin
            if (fill != '0) begin
              wordQ      <= acc[ACC_W-1 -: WORD_W];
              wordValidQ <= 1'b1;
            end
            acc   <= '0;
            fill  <= '0;
            state <= DONE;
          end
          DONE:    doneQ <= 1'b1;
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vlc_packer.sv
// Directed bench for vlc_packer: three instances cover block sizes 4, 2 and 8.
module tb_vlc_packer;

  logic iClk;
  logic iRst_n;
  logic softRst4, softRst2, softRst8;
  int   nChecks;
  int   nPass;
  int   wordCnt;

  vlc_packer_if #(.WORD_W(32), .MAX_LEN(16), .LEN_W(5)) bus4 ();
  vlc_packer_if #(.WORD_W(32), .MAX_LEN(16), .LEN_W(5)) bus2 ();
  vlc_packer_if #(.WORD_W(32), .MAX_LEN(16), .LEN_W(5)) bus8 ();

  vlc_packer #(.WORD_W(32), .MAX_LEN(16), .LEN_W(5), .BLOCK_SYMS(4), .CNT_W(7)) dut4 (
    .iClk(iClk), .iRst_n(iRst_n), .iSoftRst(softRst4), .bus(bus4.slave));
  vlc_packer #(.WORD_W(32), .MAX_LEN(16), .LEN_W(5), .BLOCK_SYMS(2), .CNT_W(7)) dut2 (
    .iClk(iClk), .iRst_n(iRst_n), .iSoftRst(softRst2), .bus(bus2.slave));
  vlc_packer #(.WORD_W(32), .MAX_LEN(16), .LEN_W(5), .BLOCK_SYMS(8), .CNT_W(7)) dut8 (
    .iClk(iClk), .iRst_n(iRst_n), .iSoftRst(softRst8), .bus(bus8.slave));

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic drive(input int sel, input logic v, input logic [15:0] c, input logic [4:0] l);
    case (sel)
      2: begin bus2.iValid = v; bus2.iCode = c; bus2.iLen = l; end
      8: begin bus8.iValid = v; bus8.iCode = c; bus8.iLen = l; end
      default: begin bus4.iValid = v; bus4.iCode = c; bus4.iLen = l; end
    endcase
  endtask

  // One accepted symbol: present for one edge, then idle the bus.
  task automatic sendSym(input int sel, input logic [15:0] c, input logic [4:0] l);
    drive(sel, 1'b1, c, l);
    tick();
    drive(sel, 1'b0, 16'h0, 5'd0);
  endtask

  initial begin
    nChecks = 0; nPass = 0;
    iRst_n = 1'b0;
    softRst4 = 1'b0; softRst2 = 1'b0; softRst8 = 1'b0;
    drive(4, 1'b0, 16'h0, 5'd0);
    drive(2, 1'b0, 16'h0, 5'd0);
    drive(8, 1'b0, 16'h0, 5'd0);
    repeat (2) @(posedge iClk);
    #1;
    check("rst_word", bus4.oWord, 32'h0);
    check("rst_wvalid", 32'(bus4.oWordValid), 32'h0);
    check("rst_done", 32'(bus4.oDone), 32'h0);
    iRst_n = 1'b1;
    #1;
    check("rst_ready", 32'(bus4.oReady), 32'h1);

    // Exact fill, block of 2: one word, empty flush
    sendSym(2, 16'h1234, 5'd16);
    check("exact_nowv", 32'(bus2.oWordValid), 32'h0);
    sendSym(2, 16'h5678, 5'd16);
    check("exact_wv", 32'(bus2.oWordValid), 32'h1);
    check("exact_word", bus2.oWord, 32'h12345678);
    tick();
    check("exact_flush_nowv", 32'(bus2.oWordValid), 32'h0);
    check("exact_flush_nodone", 32'(bus2.oDone), 32'h0);
    tick();
    check("exact_done", 32'(bus2.oDone), 32'h1);

    // Back-to-back, block of 8
    wordCnt = 0;
    drive(8, 1'b1, 16'hFFFF, 5'd16);
    for (int i = 0; i < 8; i++) begin
      check("b2b_ready", 32'(bus8.oReady), 32'h1);
      tick();
      if (bus8.oWordValid) begin
        wordCnt++;
        check("b2b_word", bus8.oWord, 32'hFFFFFFFF);
      end
    end
    drive(8, 1'b0, 16'h0, 5'd0);
    check("b2b_flush_ready", 32'(bus8.oReady), 32'h0);
    tick();
    check("b2b_flush_nowv", 32'(bus8.oWordValid), 32'h0);
    tick();
    check("b2b_count", 32'(wordCnt), 32'd4);
    check("b2b_done", 32'(bus8.oDone), 32'h1);

    // Mixed lengths, block of 4
    sendSym(4, 16'h0005, 5'd3);
    sendSym(4, 16'hABCD, 5'd16);
    sendSym(4, 16'h001F, 5'd5);
    sendSym(4, 16'h0123, 5'd12);
    check("mix_wv", 32'(bus4.oWordValid), 32'h1);
    check("mix_word", bus4.oWord, 32'hB579BF12);
    tick();
    check("mix_flush_wv", 32'(bus4.oWordValid), 32'h1);
    check("mix_flush_word", bus4.oWord, 32'h30000000);
    check("mix_flush_nodone", 32'(bus4.oDone), 32'h0);
    tick();
    check("mix_done", 32'(bus4.oDone), 32'h1);
    check("mix_done_wv", 32'(bus4.oWordValid), 32'h0);
    check("mix_done_ready", 32'(bus4.oReady), 32'h0);

    // oDone holds until restart
    for (int i = 0; i < 10; i++) begin
      tick();
      check("done_hold", 32'(bus4.oDone), 32'h1);
    end
    softRst4 = 1'b1;
    #1;
    check("srst_ready_low", 32'(bus4.oReady), 32'h0);
    tick();
    softRst4 = 1'b0;
    #1;
    check("srst_done", 32'(bus4.oDone), 32'h0);
    check("srst_ready", 32'(bus4.oReady), 32'h1);

    // Restart mid-block drops the coincident symbol and the buffered bits
    sendSym(4, 16'hFFFF, 5'd16);
    drive(4, 1'b1, 16'hFFFF, 5'd16);
    softRst4 = 1'b1;
    tick();
    softRst4 = 1'b0;
    drive(4, 1'b0, 16'h0, 5'd0);
    check("srst_drop_nowv", 32'(bus4.oWordValid), 32'h0);
    sendSym(4, 16'h1234, 5'd16);
    sendSym(4, 16'h5678, 5'd16);
    check("srst_clean_word", bus4.oWord, 32'h12345678);
    sendSym(4, 16'h0000, 5'd0);
    check("srst_cnt_ready", 32'(bus4.oReady), 32'h1);
    sendSym(4, 16'h0000, 5'd0);
    check("srst_cnt_flush", 32'(bus4.oReady), 32'h0);
    tick();
    tick();
    check("srst_blk_done", 32'(bus4.oDone), 32'h1);
    softRst4 = 1'b1;
    tick();
    softRst4 = 1'b0;

    // Async reset mid-RUN with 20 bits buffered
    sendSym(4, 16'hABCD, 5'd16);
    sendSym(4, 16'h000F, 5'd4);
    #2;
    iRst_n = 1'b0;
    #1;
    check("arst_word", bus4.oWord, 32'h0);
    check("arst_wvalid", 32'(bus4.oWordValid), 32'h0);
    check("arst_done", 32'(bus4.oDone), 32'h0);
    @(negedge iClk);
    iRst_n = 1'b1;
    #1;
    check("arst_ready", 32'(bus4.oReady), 32'h1);
    tick();

    // Length edges: zero-length counts, over-long length clamps to 16
    sendSym(4, 16'h0003, 5'd0);
    sendSym(4, 16'hFFFF, 5'd20);
    sendSym(4, 16'h0000, 5'd8);
    check("len_nowv", 32'(bus4.oWordValid), 32'h0);
    sendSym(4, 16'h00FF, 5'd8);
    check("len_wv", 32'(bus4.oWordValid), 32'h1);
    check("len_word", bus4.oWord, 32'hFFFF00FF);
    tick();
    check("len_flush_nowv", 32'(bus4.oWordValid), 32'h0);
    tick();
    check("len_done", 32'(bus4.oDone), 32'h1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
